byte_serial_alu: RTL

- Parametrised, multi-cycle integer ALU for the tile; next generation of the processor datapath behind the 8-bit dedicated I/O.
- Accepts an opcode byte plus two WIDTH-bit operands, least-significant byte first, over a valid/ready byte stream.
- Executes the operation, then returns the WIDTH-bit result as a byte stream, with carry/overflow/zero/negative/error flags.
- Adds wider operands, shifts, compares and an iterative multiplier; the top level routes these flags to uio_out.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/shift_add_mul.sv | 80 ++++++++
 rtl/byte_serial_alu.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the byte-serial ALU.
// Optional multiplier support is selected with the ALU_MUL_EN macro.
package alu_pkg;

    localparam int OPCODE_W = 4;

    // Bit positions inside the 5-bit flags bus {err, negative, zero, overflow, carry}
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
    localparam int FLAG_E = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_MUL  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
`ifdef ALU_MUL_EN
        ST_MUL    = 3'd4,
`endif
        ST_OUT    = 3'd5
    } state_e;

    // Signed overflow of a + b: operands agree in sign, result does not
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of a - b: operands differ in sign, result sign differs from a
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle.
// done pulses exactly WIDTH cycles after start; start restarts any
// computation in flight. Only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module shift_add_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               done_q, done_d;

    // One iteration: conditionally add multiplicand to upper half, then shift right
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] upper;
        upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {upper, p[WIDTH-1:1]};
    endfunction

    // Next-state: first iteration happens on the start edge, the rest while running
    always_comb begin
        p_d    = p_q;
        a_d    = a_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            p_d   = mul_step({{WIDTH{1'b0}}, b}, a);
            a_d   = a;
            cnt_d = CW'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            p_d   = mul_step(p_q, a_q);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                run_d  = 1'b1;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Multiplier state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q    <= {(2*WIDTH){1'b0}};
            a_q    <= {WIDTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            a_q    <= a_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done    = done_q;
    assign product = p_q;

endmodule
`endif

// File: rtl/byte_serial_alu.sv
// Byte-serial multi-cycle ALU: opcode byte, then A and B (LSB first) in,
// result bytes (LSB first) plus flags out over valid/ready streams.
// Define ALU_MUL_EN to add the iterative multiplier for opcode 8.
module byte_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [4:0] flags,
    output logic       busy
);

    localparam int NB  = WIDTH / 8;
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = (NB > 1) ? $clog2(NB) : 1;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [OPCODE_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic [4:0]           flags_q, flags_d;
    logic                 busy_q, busy_d;

    logic                 in_fire_s;
    logic                 out_fire_s;
    logic                 load_out_s;
    logic [WIDTH-1:0]     alu_res_s;
    logic [4:0]           alu_flags_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       diff_s;
    logic [SHW-1:0]       shamt_s;
    logic [WIDTH+7:0]     a_shift_s;
    logic [WIDTH+7:0]     b_shift_s;
    logic [WIDTH-1:0]     res_shift_s;

    // abort masks acceptance in the same cycle it is raised
    assign in_ready   = in_ready_q & ~abort;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign flags      = flags_q;
    assign busy       = busy_q;

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_q & out_ready;

    assign sum_s       = {1'b0, a_q} + {1'b0, b_q};
    assign diff_s      = {1'b0, a_q} - {1'b0, b_q};
    assign shamt_s     = b_q[SHW-1:0];
    assign a_shift_s   = {in_data, a_q};
    assign b_shift_s   = {in_data, b_q};
    assign res_shift_s = res_q >> 4'd8;

`ifdef ALU_MUL_EN
    logic                 mul_start_s;
    logic                 mul_done_s;
    logic [2*WIDTH-1:0]   mul_prod_s;

    assign mul_start_s = (state_q == ST_EXEC) && (op_q == OP_MUL) && !abort;

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (a_q),
        .b       (b_q),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );
`endif

    // Result and flag computation from the latched opcode and operands
    always_comb begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_flags_s = 5'b00000;
        case (op_q)
            OP_ADD: begin
                alu_res_s           = sum_s[WIDTH-1:0];
                alu_flags_s[FLAG_C] = sum_s[WIDTH];
                alu_flags_s[FLAG_V] = add_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s           = diff_s[WIDTH-1:0];
                alu_flags_s[FLAG_C] = diff_s[WIDTH];
                alu_flags_s[FLAG_V] = sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], diff_s[WIDTH-1]);
            end
            OP_AND:  alu_res_s = a_q & b_q;
            OP_OR:   alu_res_s = a_q | b_q;
            OP_XOR:  alu_res_s = a_q ^ b_q;
            OP_SLL:  alu_res_s = a_q << shamt_s;
            OP_SRL:  alu_res_s = a_q >> shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(a_q) >>> shamt_s);
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
`ifdef ALU_MUL_EN
            OP_MUL: begin
                alu_res_s           = mul_prod_s[WIDTH-1:0];
                alu_flags_s[FLAG_C] = |mul_prod_s[2*WIDTH-1:WIDTH];
            end
`endif
            default: begin
                alu_res_s           = {WIDTH{1'b0}};
                alu_flags_s[FLAG_E] = 1'b1;
            end
        endcase
        alu_flags_s[FLAG_Z] = (alu_res_s == {WIDTH{1'b0}});
        alu_flags_s[FLAG_N] = alu_res_s[WIDTH-1];
    end

    // Frame sequencing: load opcode/A/B, execute, stream the result out
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        flags_d     = flags_q;
        load_out_s  = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            cnt_d       = {CW{1'b0}};
            op_d        = {OPCODE_W{1'b0}};
            a_d         = {WIDTH{1'b0}};
            b_d         = {WIDTH{1'b0}};
            res_d       = {WIDTH{1'b0}};
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            out_last_d  = 1'b0;
            flags_d     = 5'b00000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_fire_s) begin
                        op_d    = in_data[OPCODE_W-1:0];
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_LOAD_A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD_A: begin
                    if (in_fire_s) begin
                        a_d = a_shift_s[WIDTH+7:8];
                        if (cnt_q == CW'(NB - 1)) begin
                            cnt_d   = {CW{1'b0}};
                            state_d = ST_LOAD_B;
                        end else begin
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end
                ST_LOAD_B: begin
                    if (in_fire_s) begin
                        b_d = b_shift_s[WIDTH+7:8];
                        if (cnt_q == CW'(NB - 1)) begin
                            cnt_d   = {CW{1'b0}};
                            state_d = ST_EXEC;
                        end else begin
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = ST_LOAD_B;
                    end
                end
                ST_EXEC: begin
`ifdef ALU_MUL_EN
                    if (op_q == OP_MUL) begin
                        state_d = ST_MUL;
                    end else begin
                        load_out_s = 1'b1;
                    end
`else
                    load_out_s = 1'b1;
`endif
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    if (mul_done_s) begin
                        load_out_s = 1'b1;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
`endif
                ST_OUT: begin
                    if (out_fire_s) begin
                        if (out_last_q) begin
                            state_d     = ST_IDLE;
                            cnt_d       = {CW{1'b0}};
                            out_valid_d = 1'b0;
                            out_data_d  = 8'h00;
                            out_last_d  = 1'b0;
                            flags_d     = 5'b00000;
                        end else begin
                            res_d       = res_shift_s;
                            out_data_d  = res_shift_s[7:0];
                            cnt_d       = cnt_q + CW'(1);
                            out_last_d  = ((cnt_q + CW'(1)) == CW'(NB - 1));
                        end
                    end else begin
                        state_d = ST_OUT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end
            endcase

            if (load_out_s) begin
                state_d     = ST_OUT;
                cnt_d       = {CW{1'b0}};
                res_d       = alu_res_s;
                out_data_d  = alu_res_s[7:0];
                out_last_d  = (NB == 1);
                out_valid_d = 1'b1;
                flags_d     = alu_flags_s;
            end else begin
                res_d = res_d;
            end
        end

        in_ready_d = !abort && ((state_d == ST_IDLE) || (state_d == ST_LOAD_A) ||
                                (state_d == ST_LOAD_B));
        busy_d     = (state_d != ST_IDLE);
    end

    // State and registered-output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            op_q        <= {OPCODE_W{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            flags_q     <= 5'b00000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            flags_q     <= flags_d;
            busy_q      <= busy_d;
        end
    end

endmodule
